// File: rtl/alu_pkg.sv
// Shared constants and types for the rysy integer ALU.
// The decoder and the control unit import the same opcode encoding.
package alu_pkg;

    // Operand and result width of the RV32I datapath.
    localparam int REG_LEN = 32;

    // Width of the shift-amount field taken from operand B.
    localparam int SHAMT_LEN = 5;

    // Operation select. Codes 10..15 are reserved and produce 0.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Only the low five bits of operand B select a shift distance;
    // B[31:5] is deliberately ignored, matching RV32I shift semantics.
    function automatic logic [SHAMT_LEN-1:0] shamt_of(input logic [REG_LEN-1:0] b);
        return b[SHAMT_LEN-1:0];
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the execute stage and the ALU.
// There is no valid/ready pair: the pipeline presents operands every
// cycle and the ALU accepts a new operation on every rising edge, so a
// transfer happens unconditionally each clock.
interface alu_if;
    import alu_pkg::*;

    logic [REG_LEN-1:0] alu_in1;  // operand A (rs1 / PC)
    logic [REG_LEN-1:0] alu_in2;  // operand B (rs2 / immediate)
    logic [3:0]         alu_op;   // operation select
    logic [REG_LEN-1:0] alu_out;  // registered result

    // Execute stage side: drives operands, observes the result.
    modport master (
        output alu_in1,
        output alu_in2,
        output alu_op,
        input  alu_out
    );

    // ALU side: consumes operands, drives the result.
    modport slave (
        input  alu_in1,
        input  alu_in2,
        input  alu_op,
        output alu_out
    );
endinterface

// File: rtl/alu.sv
// RV32I integer ALU: one combinational case on the opcode feeding a
// single result register. One cycle latency, one operation per cycle.
module alu
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    alu_if.slave   bus
);

    logic [REG_LEN-1:0]   alu_out_q;
    logic [REG_LEN-1:0]   result_d;
    logic [SHAMT_LEN-1:0] shamt;

    assign shamt = shamt_of(bus.alu_in2);

    // Result mux; the default arm forces reserved opcodes to 0 and
    // keeps the block free of latches.
    always_comb begin
        result_d = '0;
        case (bus.alu_op)
            ALU_ADD:  result_d = bus.alu_in1 + bus.alu_in2;
            ALU_SUB:  result_d = bus.alu_in1 - bus.alu_in2;
            ALU_SLL:  result_d = bus.alu_in1 << shamt;
            ALU_SLT:  result_d = {{(REG_LEN-1){1'b0}},
                                  ($signed(bus.alu_in1) < $signed(bus.alu_in2))};
            ALU_SLTU: result_d = {{(REG_LEN-1){1'b0}},
                                  (bus.alu_in1 < bus.alu_in2)};
            ALU_XOR:  result_d = bus.alu_in1 ^ bus.alu_in2;
            ALU_SRL:  result_d = bus.alu_in1 >> shamt;
            ALU_SRA:  result_d = $unsigned($signed(bus.alu_in1) >>> shamt);
            ALU_OR:   result_d = bus.alu_in1 | bus.alu_in2;
            ALU_AND:  result_d = bus.alu_in1 & bus.alu_in2;
            default:  result_d = '0;
        endcase
    end

    // Result register; reset has priority over the computed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= result_d;
        end
    end

    assign bus.alu_out = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// Randomised and directed bench for the ALU, checked against an
// arithmetic reference model with a one-deep expected queue.
module tb_alu;

    logic clk;
    logic rst;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    logic        last_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [3:0]  op);
        longint ua, ub, sa, sb, p, r;
        int     sh;
        logic [63:0] t;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(ub % 32);
        p  = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        r = 0;
        case (op)
            4'd0: r = ua + ub;
            4'd1: r = ua - ub;
            4'd2: r = ua * p;
            4'd3: r = (sa < sb) ? 1 : 0;
            4'd4: r = (ua < ub) ? 1 : 0;
            4'd5: r = longint'({32'b0, a ^ b});
            4'd6: r = ua / p;
            4'd7: begin
                r = sa / p;
                if ((sa % p) != 0 && sa < 0) r = r - 1;
            end
            4'd8: r = longint'({32'b0, a | b});
            4'd9: r = longint'({32'b0, a & b});
            default: r = 0;
        endcase
        t = r;
        return t[31:0];
    endfunction

    // ---------------- driver ----------------
    // Drives one operation just after an edge, confirms the output has not
    // yet moved, then checks the result one edge later.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic r, input string tag);
        logic [31:0] e;
        bus.alu_in1 = a;
        bus.alu_in2 = b;
        bus.alu_op  = op;
        rst         = r;
        exp_q.push_back(r ? 32'd0 : ref_alu(a, b, op));
        #1;
        if (last_valid) check_val({tag, "_hold"}, bus.alu_out, last_exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val(tag, bus.alu_out, e);
        last_exp   = e;
        last_valid = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b;
        logic [3:0]  op;
        bus.alu_in1 = 32'd0;
        bus.alu_in2 = 32'd0;
        bus.alu_op  = 4'd0;
        rst         = 1'b1;
        @(posedge clk);
        #1;

        // Reset holds output at 0, release loads 12.
        step(32'd10, 32'd2, 4'd0, 1'b1, "rst_hold");
        check_val("rst_zero", bus.alu_out, 32'd0);
        step(32'd10, 32'd2, 4'd0, 1'b0, "rst_release");
        check_val("first_add", bus.alu_out, 32'd12);

        // Basic ops, back-to-back through all 16 codes including reserved.
        for (int i = 0; i < 16; i++)
            step(32'd10, 32'd2, 4'(i), 1'b0, $sformatf("basic_op%0d", i));
        check_val("and_10_2", bus.alu_out, 32'd0); // op 15 reserved

        // Signed vs unsigned and shift masking cases.
        for (int i = 0; i < 10; i++) begin
            step(32'hFFFFFFFC, 32'd4,        4'(i), 1'b0, $sformatf("neg4_op%0d", i));
            step(32'd4,        32'hFFFFFFFC, 4'(i), 1'b0, $sformatf("pos4_op%0d", i));
            step(32'd3,        32'd10,       4'(i), 1'b0, $sformatf("3_10_op%0d", i));
            step(32'hFFFFFFF0, 32'd2,        4'(i), 1'b0, $sformatf("neg16_op%0d", i));
            step(32'hFFFFFFF0, 32'h22,       4'(i), 1'b0, $sformatf("mask_op%0d", i));
            step(32'h80000001, 32'd31,       4'(i), 1'b0, $sformatf("sh31_op%0d", i));
            step(32'h12345678, 32'h12345678, 4'(i), 1'b0, $sformatf("eq_op%0d", i));
        end

        // A few literal spot checks from the plan.
        step(32'hFFFFFFFC, 32'd4, 4'd7, 1'b0, "sra_neg4");
        check_val("sra_neg4_lit", bus.alu_out, 32'hFFFFFFFF);
        step(32'hFFFFFFFC, 32'd4, 4'd6, 1'b0, "srl_neg4");
        check_val("srl_neg4_lit", bus.alu_out, 32'h0FFFFFFF);
        step(32'd3, 32'd10, 4'd1, 1'b0, "sub_3_10");
        check_val("sub_3_10_lit", bus.alu_out, 32'hFFFFFFF9);
        step(32'hFFFFFFF0, 32'h22, 4'd2, 1'b0, "sll_mask");
        check_val("sll_mask_lit", bus.alu_out, 32'hFFFFFFC0);

        // Reset asserted mid-sequence, then resume.
        step(32'd10, 32'd2, 4'd0, 1'b0, "mid_pre");
        step(32'd10, 32'd2, 4'd0, 1'b1, "mid_rst");
        step(32'd10, 32'd2, 4'd1, 1'b0, "mid_post");

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            op = 4'($urandom_range(0, 15));
            step(a, b, op, ($urandom_range(0, 24) == 0), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $finish;
    end

endmodule
